init_seq: RTL and testbench

- Responder end of the top-level init handshake.
- Receives a one-cycle init_start from the top-level control state machine. It then waits out a power-up delay and walks a register table, issuing one write per entry to the I2C master command interface. When finished it raises init_done.
- Sits between the top-level controller and the shared I2C master that configures the HDMI transmitter and cameras.

---
 rtl/init_seq_pkg.sv | 27 ++
 rtl/init_seq_if.sv | 28 ++
 rtl/init_rom.sv | 39 +++
 rtl/init_seq.sv | 170 +++++++++++++++++
 tb/tb_init_seq.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/init_seq_pkg.sv
// Shared definitions for the init sequencer: sequencer states, table entry
// field widths and the marker that turns a table entry into a pause.
package init_seq_pkg;

  localparam int unsigned RegW  = 8;
  localparam int unsigned DataW = 8;

  // A table entry with this register address is a delay of data*DLY_UNIT cycles.
  localparam logic [RegW-1:0] DlyMarker = 8'hFF;

  typedef enum logic [3:0] {
    StIdle,
    StPwrWait,
    StFetch,
    StIssue,
    StWait,
    StDly,
    StNext,
    StDone,
    StErr
  } state_e;

  function automatic logic is_dly_entry(input logic [RegW-1:0] reg_addr);
    return reg_addr == DlyMarker;
  endfunction

endpackage

// File: rtl/init_seq_if.sv
// Command channel between the init sequencer and the shared I2C master.
//   cmd_valid/cmd_ready : write command handshake (transfer on valid & ready)
//   cmd_dev/reg/data    : 7-bit device address, register address, write data
//   i2c_done            : one-cycle pulse when an accepted transfer finishes
//   i2c_nack            : qualified by i2c_done, 1 = slave NACKed
// master: the sequencer side; slave: the I2C master side.
interface init_seq_if;
  import init_seq_pkg::*;

  logic             cmd_valid;
  logic             cmd_ready;
  logic [6:0]       cmd_dev;
  logic [RegW-1:0]  cmd_reg;
  logic [DataW-1:0] cmd_data;
  logic             i2c_done;
  logic             i2c_nack;

  modport master (
    output cmd_valid, cmd_dev, cmd_reg, cmd_data,
    input  cmd_ready, i2c_done, i2c_nack
  );

  modport slave (
    input  cmd_valid, cmd_dev, cmd_reg, cmd_data,
    output cmd_ready, i2c_done, i2c_nack
  );

endinterface

// File: rtl/init_rom.sv
// Register table for the HDMI transmitter bring-up. Purely combinational.
//   idx   : table index (zero-extended to 8 bits)
//   entry : {reg, data}; reg = 8'hFF marks a delay entry
// Indices at or beyond NUM_REGS return a zero-length delay, i.e. a no-op.
module init_rom
  import init_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic [7:0]              idx,
  output logic [RegW+DataW-1:0]   entry
);

  always_comb begin
    entry = {DlyMarker, 8'h00};
    if (32'(idx) < NUM_REGS) begin
      case (idx)
        8'd0:    entry = {8'h41, 8'h10};  // leave power-down
        8'd1:    entry = {8'h98, 8'h03};
        8'd2:    entry = {8'h9A, 8'hE0};
        8'd3:    entry = {DlyMarker, 8'h02};  // let the core settle after power-up
        8'd4:    entry = {8'h9C, 8'h30};
        8'd5:    entry = {8'h9D, 8'h61};
        8'd6:    entry = {8'hA2, 8'hA4};
        8'd7:    entry = {8'hA3, 8'hA4};
        8'd8:    entry = {8'hE0, 8'hD0};
        8'd9:    entry = {8'hF9, 8'h00};
        8'd10:   entry = {8'h15, 8'h00};
        8'd11:   entry = {8'h16, 8'h30};
        8'd12:   entry = {8'h17, 8'h02};
        8'd13:   entry = {8'h18, 8'h46};
        8'd14:   entry = {8'hAF, 8'h06};
        8'd15:   entry = {8'hD6, 8'hC0};
        default: entry = {DlyMarker, 8'h00};
      endcase
    end
  end

endmodule

// File: rtl/init_seq.sv
// Init sequencer: on init_start waits STARTUP_DLY cycles, then walks the register
// table issuing one I2C write per entry (delay entries pause instead), retrying
// NACKed writes up to MAX_RETRY times.
//   clk, reset  : clock, asynchronous active-low reset
//   init_start  : one-cycle request, accepted only when idle, done or in error
//   init_done   : high once the whole table was written
//   init_err    : high once an entry ran out of retries
//   bus         : command channel to the I2C master (master modport)
module init_seq
  import init_seq_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [6:0]  DEV_ADDR    = 7'h39,
  parameter int unsigned STARTUP_DLY = 1000,
  parameter int unsigned DLY_UNIT    = 1000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  output logic       init_done,
  output logic       init_err,
  init_seq_if.master bus
);

  localparam int unsigned IdxW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(NUM_REGS - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

  state_e             state_q, state_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [RetryW-1:0]  retry_q, retry_d;
  logic [31:0]        dly_q, dly_d;
  logic [RegW-1:0]    reg_q, reg_d;
  logic [DataW-1:0]   data_q, data_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic [7:0]             rom_idx;
  logic [RegW+DataW-1:0]  rom_entry;
  logic [RegW-1:0]        rom_reg;
  logic [DataW-1:0]       rom_data;

  assign rom_idx  = 8'(idx_q);
  assign rom_reg  = rom_entry[RegW+DataW-1:DataW];
  assign rom_data = rom_entry[DataW-1:0];

  init_rom #(
    .NUM_REGS(NUM_REGS)
  ) u_rom (
    .idx  (rom_idx),
    .entry(rom_entry)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    retry_d = retry_q;
    dly_d   = dly_q;
    reg_d   = reg_q;
    data_d  = data_q;
    valid_d = valid_q;
    done_d  = done_q;
    err_d   = err_q;

    case (state_q)
      StIdle, StDone, StErr: begin
        if (init_start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          dly_d   = 32'(STARTUP_DLY) - 32'd1;
          idx_d   = '0;
          state_d = StPwrWait;
        end
      end
      StPwrWait: begin
        if (dly_q == 32'd0) state_d = StFetch;
        else                dly_d   = dly_q - 32'd1;
      end
      StFetch: begin
        reg_d   = rom_reg;
        data_d  = rom_data;
        retry_d = '0;
        if (is_dly_entry(rom_reg)) begin
          if (rom_data == '0) begin
            state_d = StNext;
          end else begin
            dly_d   = 32'(rom_data) * DLY_UNIT - 32'd1;
            state_d = StDly;
          end
        end else begin
          // valid is registered, so raise it on the way into StIssue
          valid_d = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (bus.cmd_ready) begin
          valid_d = 1'b0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.i2c_done) begin
          if (!bus.i2c_nack) begin
            state_d = StNext;
          end else if (retry_q < RetryMax) begin
            retry_d = retry_q + 1'b1;
            valid_d = 1'b1;
            state_d = StIssue;
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StDly: begin
        if (dly_q == 32'd0) state_d = StNext;
        else                dly_d   = dly_q - 32'd1;
      end
      StNext: begin
        if (idx_q == LastIdx) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = StFetch;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      retry_q <= '0;
      dly_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      retry_q <= retry_d;
      dly_q   <= dly_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign init_done    = done_q;
  assign init_err     = err_q;
  assign bus.cmd_valid = valid_q;
  assign bus.cmd_dev   = DEV_ADDR;
  assign bus.cmd_reg   = reg_q;
  assign bus.cmd_data  = data_q;

endmodule

// File: tb/tb_init_seq.sv
// Bench for init_seq: a behavioural I2C master answers commands, expected
// commands are queued by the stimulus and checked by a separate monitor.
module tb_init_seq;

  localparam logic [6:0] Dev = 7'h39;

  logic clk = 1'b0;
  logic reset;
  logic init_start;
  logic init_done;
  logic init_err;
  int   cyc = 0;

  init_seq_if bus ();

  init_seq #(
    .NUM_REGS   (5),
    .DEV_ADDR   (Dev),
    .STARTUP_DLY(10),
    .DLY_UNIT   (5),
    .MAX_RETRY  (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init_start(init_start),
    .init_done (init_done),
    .init_err  (init_err),
    .bus       (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int         n_chk = 0;
  int         n_err = 0;
  logic [22:0] exp_q[$];
  bit          nack_q[$];
  int          txn_n = 0;
  int          t_first[64];
  int          t_done[64];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, got, req);
    end
  endtask

  // Monitor: every accepted command must match the head of the expected queue.
  initial begin : monitor
    logic [22:0] exp;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL cmd_unexpected: got dev=%h reg=%h data=%h, required no command",
                   bus.cmd_dev, bus.cmd_reg, bus.cmd_data);
        end else begin
          exp = exp_q.pop_front();
          if ({bus.cmd_dev, bus.cmd_reg, bus.cmd_data} !== exp) begin
            n_err++;
            $display("FAIL cmd_value: got dev=%h reg=%h data=%h, required dev=%h reg=%h data=%h",
                     bus.cmd_dev, bus.cmd_reg, bus.cmd_data, exp[22:16], exp[15:8], exp[7:0]);
          end
        end
      end
    end
  end

  // I2C master model: ready one cycle after valid is seen, done 5 cycles after accept.
  initial begin : master
    bus.cmd_ready = 1'b0;
    bus.i2c_done  = 1'b0;
    bus.i2c_nack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.cmd_valid === 1'b1) begin
        if (txn_n < 64) t_first[txn_n] = cyc;
        @(posedge clk); #1; bus.cmd_ready = 1'b1;
        @(posedge clk); #1; bus.cmd_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.i2c_done = 1'b1;
        bus.i2c_nack = (nack_q.size() > 0) ? nack_q.pop_front() : 1'b0;
        @(posedge clk); #1;
        bus.i2c_done = 1'b0;
        bus.i2c_nack = 1'b0;
        if (txn_n < 64) t_done[txn_n] = cyc;
        txn_n++;
      end
    end
  end

  task automatic push_cmd(input logic [7:0] r, input logic [7:0] d);
    exp_q.push_back({Dev, r, d});
  endtask

  // Commands of one full pass over the 5-entry table (entry 3 is a delay).
  task automatic push_run();
    push_cmd(8'h41, 8'h10);
    push_cmd(8'h98, 8'h03);
    push_cmd(8'h9A, 8'hE0);
    push_cmd(8'h9C, 8'h30);
  endtask

  task automatic pulse_start(output int ts);
    @(posedge clk); #1; init_start = 1'b1;
    @(posedge clk); #1; init_start = 1'b0;
    ts = cyc;
  endtask

  task automatic wait_for(input bit want_err, input int budget, input string name,
                          output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if ((want_err ? init_err : init_done) === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s: got timeout after %0d cycles, required rise", name, budget);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int  ts;
    int  t;
    int  base;
    bit  seen;

    reset      = 1'b0;
    init_start = 1'b0;
    #23;
    chk("rst_done", 32'(init_done), 0);
    chk("rst_err", 32'(init_err), 0);
    chk("rst_valid", 32'(bus.cmd_valid), 0);
    chk("rst_reg", 32'(bus.cmd_reg), 0);
    chk("rst_data", 32'(bus.cmd_data), 0);
    #7 reset = 1'b1;

    // Basic run with timing of start-up, normal gap and delay-entry gap.
    base = txn_n;
    push_run();
    pulse_start(ts);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.cmd_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("startup_quiet", 32'(seen), 0);
    wait_for(1'b0, 300, "basic_done", t);
    chk("basic_latency", t - ts, 58);
    chk("first_valid_lat", t_first[base] - ts, 11);
    chk("gap_normal", t_first[base+1] - t_done[base], 2);
    chk("gap_delay", t_first[base+3] - t_done[base+2], 14);
    chk("basic_txns", txn_n - base, 4);
    chk("basic_queue", exp_q.size(), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("basic_done_held", 32'(init_done), 1);
    chk("basic_err", 32'(init_err), 0);

    // NACK twice on entry 0, then ACK.
    base = txn_n;
    nack_q = '{1'b1, 1'b1, 1'b0};
    push_cmd(8'h41, 8'h10);
    push_cmd(8'h41, 8'h10);
    push_run();
    pulse_start(ts);
    wait_for(1'b0, 400, "nack_done", t);
    chk("nack_err", 32'(init_err), 0);
    chk("nack_txns", txn_n - base, 6);
    chk("nack_queue", exp_q.size(), 0);

    // Persistent NACK on entry 1 exhausts retries.
    base = txn_n;
    nack_q = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    push_cmd(8'h41, 8'h10);
    for (int i = 0; i < 4; i++) push_cmd(8'h98, 8'h03);
    pulse_start(ts);
    wait_for(1'b1, 400, "exhaust_err", t);
    chk("exhaust_done", 32'(init_done), 0);
    chk("exhaust_queue", exp_q.size(), 0);
    repeat (20) @(posedge clk);
    #1;
    chk("exhaust_txns", txn_n - base, 5);
    chk("exhaust_err_held", 32'(init_err), 1);
    base = txn_n;
    push_run();
    pulse_start(ts);
    chk("restart_err_clr", 32'(init_err), 0);
    wait_for(1'b0, 300, "restart_done", t);
    chk("restart_err", 32'(init_err), 0);
    chk("restart_txns", txn_n - base, 4);
    chk("restart_queue", exp_q.size(), 0);

    // Asynchronous reset while the first transfer is in flight.
    push_cmd(8'h41, 8'h10);
    pulse_start(ts);
    t = -1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        t = cyc;
        break;
      end
    end
    chk("arst_accepted", 32'(t >= 0), 1);
    #3;
    chk("arst_pre_reg", 32'(bus.cmd_reg), 32'h41);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.cmd_valid), 0);
    chk("arst_reg", 32'(bus.cmd_reg), 0);
    chk("arst_data", 32'(bus.cmd_data), 0);
    chk("arst_done", 32'(init_done), 0);
    #20 reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.cmd_valid === 1'b1 || init_done === 1'b1) seen = 1'b1;
    end
    chk("arst_idle", 32'(seen), 0);
    base = txn_n;
    push_run();
    pulse_start(ts);
    wait_for(1'b0, 300, "arst_rerun_done", t);
    chk("arst_rerun_txns", txn_n - base, 4);
    chk("arst_rerun_queue", exp_q.size(), 0);

    // Second init_start during StIssue is ignored; done stays low for the whole run.
    base = txn_n;
    push_run();
    pulse_start(ts);
    chk("rerun_done_drop", 32'(init_done), 0);
    seen = 1'b0;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (init_done === 1'b1) seen = 1'b1;
      if (bus.cmd_valid === 1'b1) begin
        t = cyc;
        break;
      end
    end
    chk("ignore_valid_seen", 32'(t >= 0), 1);
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
    chk("ignore_early_done", 32'(seen), 0);
    wait_for(1'b0, 300, "ignore_done", t);
    chk("ignore_latency", t - ts, 58);
    chk("ignore_txns", txn_n - base, 4);
    chk("ignore_queue", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
